branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline. A direct-mapped table of 2-bit saturating counters and a tagged branch target buffer (BTB) are read combinationally with the Fetch-stage PC to produce a next-PC prediction. Tables are trained from the Execute stage using the resolved branch/jump outcome. The block also flags mispredictions and supplies the redirect PC that the hazard unit uses to flush Decode/Execute.

## Interface
Parameters:
- INDEX_BITS, 6, table index width; 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2]
- XLEN, 32, PC/target width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- PCF  in  XLEN  Fetch-stage PC
- PredTakenF  out  1  prediction: redirect fetch to PredTargetF
- PredTargetF  out  XLEN  predicted target (BTB target on hit, else 0)
- ValidE  in  1  Execute stage holds a real instruction (0 for bubble/flushed)
- BranchE, JumpE, jalrE  in  1 each  decoded control of the Execute instruction
- TakenE  in  1  actual outcome (branch condition true, or any jump)
- PCE, PCPlus4E, PCTargetE  in  XLEN  Execute PC, fall-through PC, resolved target
- PredTakenE, PredTargetE  in  1 / XLEN  prediction carried down the pipeline with the instruction
- MispredictE  out  1  Execute instruction was mispredicted
- RedirectPCE  out  XLEN  correct next PC when MispredictE=1
- BranchCount, MispredCount  out  32 each  statistics (see Configuration)

## Operation
- Entry: valid (1), tag = PC[XLEN-1:INDEX_BITS+2], target (XLEN), counter (2).
- Lookup (F): hit = valid && tag match. PredTakenF = hit && counter[1]. PredTargetF = hit ? target : 0.
- Mispredict (E, combinational, only when ValidE): MispredictE = (PredTakenE != TakenE) || (PredTakenE && TakenE && PredTargetE != PCTargetE). RedirectPCE = TakenE ? PCTargetE : PCPlus4E. ValidE=0 forces MispredictE=0.
- Update (E, registered), with idx/tag taken from PCE:
  - BranchE, hit: counter inc (sat 11) if TakenE, else dec (sat 00); target <= PCTargetE if TakenE.
  - BranchE, miss, TakenE: allocate, valid=1, tag, target=PCTargetE, counter=10.
  - BranchE, miss, not taken: no write.
  - JumpE && !jalrE (jal): allocate/overwrite, counter=11, target=PCTargetE.
  - jalrE: never allocated; if hit, the entry is invalidated (indirect targets not predicted).
  - No branch/jump but hit with PredTakenE=1 (alias): invalidate entry.
  - ValidE=0: no update.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

## Timing
- Lookup and mispredict outputs are purely combinational; zero-cycle latency.
- Table writes take effect at the rising edge; a lookup in the same cycle as a write to the same index returns the pre-write contents. The new value is visible from the next cycle.
- Reset: all valid=0, counters=01, targets=0, stats=0; PredTakenF=0, PredTargetF=0 while reset is asserted. MispredictE and RedirectPCE follow inputs. Reset mid-update discards the write.
- One update per cycle max; no stall input. The instruction in E is frozen by the pipeline when stalled, and the pipeline deasserts ValidE on repeat cycles so training happens only once.

## Configuration
- BP_STATS_EN defined: BranchCount increments on each ValidE cycle with BranchE||JumpE. MispredCount increments on each cycle with MispredictE=1. Both saturate at 0xFFFFFFFF.
- Not defined: both outputs are tied to 0 and no counter registers are synthesized. Prediction behaviour is identical in both cases.

## Test plan
- Reset, then PCF=0x40 -> PredTakenF=0, PredTargetF=0; all 64 entries invalid.
- beq at PCE=0x40 taken to 0x20, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x20; next cycle PCF=0x40 gives PredTakenF=1, PredTargetF=0x20 (counter 10).
- Same branch resolved not-taken twice -> counter 10->01->00; PCF=0x40 gives PredTakenF=0; not-taken with PredTakenE=1 -> RedirectPCE=PCPlus4E=0x44.
- jal at 0x80 to 0x100 -> counter=11, prediction hit; a later jalr at 0x80 (aliasing entry) invalidates it -> PredTakenF=0.
- Aliasing: a non-branch at 0x1080 (same index and tag as an entry) with PredTakenE=1 -> MispredictE=1, RedirectPCE=0x1084, entry invalidated. Same-cycle read/write at one index returns the old value.
- With BP_STATS_EN: 10 branches with 3 mispredicts -> BranchCount=10, MispredCount=3. Without the macro, both read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit counters + tagged BTB, trained from Execute.
// Latency: lookup and mispredict outputs are combinational (0 cycles); table writes land at the next rising edge.
// Backpressure: none; one training update per cycle, the pipeline gates repeats via ValidE.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            jalrE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

  // Table storage, one element per entry
  logic                entry_valid  [ENTRIES];
  logic [TAG_BITS-1:0] entry_tag    [ENTRIES];
  logic [XLEN-1:0]     entry_target [ENTRIES];
  logic [1:0]          entry_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;

  // Instruction-aligned PCs: the two low bits never select anything
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[XLEN-1:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[XLEN-1:INDEX_BITS+2];

  assign hit_f = entry_valid[idx_f] && (entry_tag[idx_f] == tag_f);
  assign hit_e = entry_valid[idx_e] && (entry_tag[idx_e] == tag_e);

  // Fetch-side prediction, forced quiet while reset is held
  always_comb begin
    PredTakenF  = 1'b0;
    PredTargetF = '0;
    if (!reset && hit_f) begin
      PredTakenF  = entry_ctr[idx_f][1];
      PredTargetF = entry_target[idx_f];
    end
  end

  // Execute-side misprediction detection and correct next PC
  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = TakenE ? PCTargetE : PCPlus4E;
    if (ValidE) begin
      MispredictE = (PredTakenE != TakenE) ||
                    (PredTakenE && TakenE && (PredTargetE != PCTargetE));
    end
  end

  logic                wr_en;
  logic                new_valid;
  logic [TAG_BITS-1:0] new_tag;
  logic [XLEN-1:0]     new_target;
  logic [1:0]          new_ctr;

  // Training decision: build the replacement entry from the current one
  always_comb begin
    wr_en      = 1'b0;
    new_valid  = entry_valid[idx_e];
    new_tag    = entry_tag[idx_e];
    new_target = entry_target[idx_e];
    new_ctr    = entry_ctr[idx_e];
    if (ValidE) begin
      if (jalrE) begin
        // Indirect targets are not predicted: drop any entry this PC hits
        if (hit_e) begin
          wr_en     = 1'b1;
          new_valid = 1'b0;
        end
      end else if (JumpE) begin
        wr_en      = 1'b1;
        new_valid  = 1'b1;
        new_tag    = tag_e;
        new_target = PCTargetE;
        new_ctr    = 2'b11;
      end else if (BranchE) begin
        if (hit_e) begin
          wr_en = 1'b1;
          if (TakenE) begin
            new_ctr    = (entry_ctr[idx_e] == 2'b11) ? 2'b11 : entry_ctr[idx_e] + 2'd1;
            new_target = PCTargetE;
          end else begin
            new_ctr = (entry_ctr[idx_e] == 2'b00) ? 2'b00 : entry_ctr[idx_e] - 2'd1;
          end
        end else if (TakenE) begin
          wr_en      = 1'b1;
          new_valid  = 1'b1;
          new_tag    = tag_e;
          new_target = PCTargetE;
          new_ctr    = 2'b10;
        end
      end else if (hit_e && PredTakenE) begin
        // A non-control instruction aliased onto a taken entry
        wr_en     = 1'b1;
        new_valid = 1'b0;
      end
    end
  end

  // Table state: async clear, single write port indexed by the Execute PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_ctr[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      entry_valid[idx_e]  <= new_valid;
      entry_tag[idx_e]    <= new_tag;
      entry_target[idx_e] <= new_target;
      entry_ctr[idx_e]    <= new_ctr;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      if (ValidE && (BranchE || JumpE) && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (MispredictE && (mispred_count != 32'hFFFF_FFFF))
        mispred_count <= mispred_count + 32'd1;
    end
  end

  assign BranchCount  = branch_count;
  assign MispredCount = mispred_count;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue-based scoreboard.
// Stimulus drives just after the rising edge and queues expectations; the monitor checks on the falling edge.
// Statistics expectations depend on whether BP_STATS_EN is defined.
module tb_branch_predictor;

  localparam int XLEN = 32;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic            ValidE, BranchE, JumpE, jalrE, TakenE;
  logic [XLEN-1:0] PCE, PCPlus4E, PCTargetE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic            MispredictE;
  logic [XLEN-1:0] RedirectPCE;
  logic [31:0]     BranchCount, MispredCount;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .jalrE(jalrE), .TakenE(TakenE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  typedef enum int {K_PTF, K_PTG, K_MISP, K_REDIR, K_BCNT, K_MCNT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input kind_t k, input logic [31:0] v, input string n);
    chk_t c;
    c.kind = k;
    c.exp  = v;
    c.name = n;
    sbq.push_back(c);
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_PTF:   return {31'd0, PredTakenF};
      K_PTG:   return PredTargetF;
      K_MISP:  return {31'd0, MispredictE};
      K_REDIR: return RedirectPCE;
      K_BCNT:  return BranchCount;
      default: return MispredCount;
    endcase
  endfunction

  // Immediate check of a live output against a required value
  task automatic check_now(input kind_t k, input logic [31:0] v, input string n);
    logic [31:0] act;
    act = observe(k);
    checks++;
    if (act !== v) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", n, act, v);
    end
  endtask

  // Monitor: drain everything queued for this cycle against the live outputs
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c   = sbq.pop_front();
      act = observe(c.kind);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: actual=0x%0h required=0x%0h", c.name, act, c.exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_e();
    ValidE = 1'b0; BranchE = 1'b0; JumpE = 1'b0; jalrE = 1'b0; TakenE = 1'b0;
    PCE = '0; PCPlus4E = 32'd4; PCTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
  endtask

  task automatic drive_e(input logic v, input logic br, input logic j, input logic jr,
                         input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptg);
    ValidE = v; BranchE = br; JumpE = j; jalrE = jr; TakenE = tk;
    PCE = pce; PCPlus4E = pce + 32'd4; PCTargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptg;
  endtask

  // One resolved instruction in Execute, with hand-computed mispredict/redirect
  task automatic train(input logic br, input logic j, input logic jr, input logic tk,
                       input logic [31:0] pce, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptg,
                       input logic em, input logic [31:0] er, input string n);
    drive_e(1'b1, br, j, jr, tk, pce, tgt, ptk, ptg);
    expect_out(K_MISP, {31'd0, em}, {n, "_misp"});
    expect_out(K_REDIR, er, {n, "_redir"});
    next_cycle();
  endtask

  // Fetch lookup with an idle Execute stage
  task automatic probe(input logic [31:0] pcf, input logic ep, input logic [31:0] et, input string n);
    idle_e();
    PCF = pcf;
    expect_out(K_PTF, {31'd0, ep}, {n, "_ptf"});
    expect_out(K_PTG, et, {n, "_ptg"});
    next_cycle();
  endtask

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    PCF   = 32'h40;
    idle_e();
    #1 reset = 1'b1;
    #1;
    check_now(K_PTF, 0, "reset_now_ptf");
    check_now(K_PTG, 0, "reset_now_ptg");
    next_cycle();
    expect_out(K_PTF, 0, "reset_ptf");
    expect_out(K_PTG, 0, "reset_ptg");
    expect_out(K_MISP, 0, "reset_misp");
    next_cycle();
    reset = 1'b0;

    // Every entry starts invalid
    for (int i = 0; i < 64; i++) probe(32'(i) << 2, 1'b0, 32'h0, "empty");
    expect_out(K_BCNT, 0, "reset_bcnt");
    expect_out(K_MCNT, 0, "reset_mcnt");
    next_cycle();

    // Taken beq allocates; same-cycle lookup sees the old (empty) entry
    PCF = 32'h40;
    expect_out(K_PTF, 0, "alloc_same_cycle_ptf");
    train(1, 0, 0, 1, 32'h40, 32'h20, 0, 32'h0, 1'b1, 32'h20, "beq_alloc");
    probe(32'h40, 1'b1, 32'h20, "after_alloc");

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
    train(1, 0, 0, 0, 32'h40, 32'h20, 1, 32'h20, 1'b1, 32'h44, "nt1");
    probe(32'h40, 1'b0, 32'h20, "ctr01");
    train(1, 0, 0, 0, 32'h40, 32'h20, 0, 32'h0, 1'b0, 32'h44, "nt2");
    probe(32'h40, 1'b0, 32'h20, "ctr00");
    train(1, 0, 0, 0, 32'h40, 32'h20, 0, 32'h0, 1'b0, 32'h44, "nt3");
    probe(32'h40, 1'b0, 32'h20, "ctr00_sat");
    train(1, 0, 0, 1, 32'h40, 32'h20, 0, 32'h0, 1'b1, 32'h20, "tk1");
    probe(32'h40, 1'b0, 32'h20, "ctr01_up");
    train(1, 0, 0, 1, 32'h40, 32'h20, 0, 32'h0, 1'b1, 32'h20, "tk2");
    probe(32'h40, 1'b1, 32'h20, "ctr10_up");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "tk3");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "tk4");
    train(1, 0, 0, 0, 32'h40, 32'h20, 1, 32'h20, 1'b1, 32'h44, "nt_from11");
    probe(32'h40, 1'b1, 32'h20, "ctr11_sat");
    // Correct direction, wrong target: mispredict and retarget
    train(1, 0, 0, 1, 32'h40, 32'h30, 1, 32'h20, 1'b1, 32'h30, "retarget");
    probe(32'h40, 1'b1, 32'h30, "after_retarget");

    // jal allocates strongly taken; a not-taken branch leaves it at weak taken
    train(0, 1, 0, 1, 32'h80, 32'h100, 0, 32'h0, 1'b1, 32'h100, "jal");
    probe(32'h80, 1'b1, 32'h100, "after_jal");
    train(1, 0, 0, 0, 32'h80, 32'h100, 1, 32'h100, 1'b1, 32'h84, "jal_entry_nt");
    probe(32'h80, 1'b1, 32'h100, "jal_ctr11");
    // jalr invalidates a hit and never allocates
    train(0, 1, 1, 1, 32'h80, 32'h200, 1, 32'h100, 1'b1, 32'h200, "jalr_hit");
    probe(32'h80, 1'b0, 32'h0, "after_jalr");
    train(0, 1, 1, 1, 32'h80, 32'h200, 0, 32'h0, 1'b1, 32'h200, "jalr_miss");
    probe(32'h80, 1'b0, 32'h0, "jalr_no_alloc");

    // Same index, different tag: 0x1080 vs 0x80
    train(0, 1, 0, 1, 32'h1080, 32'h300, 0, 32'h0, 1'b1, 32'h300, "jal1080");
    probe(32'h80, 1'b0, 32'h0, "tag_mismatch");
    probe(32'h1080, 1'b1, 32'h300, "tag_match");
    // Non-branch aliasing the taken entry: same-cycle read still sees it
    PCF = 32'h1080;
    expect_out(K_PTF, 1, "alias_same_cycle_ptf");
    expect_out(K_PTG, 32'h300, "alias_same_cycle_ptg");
    train(0, 0, 0, 0, 32'h1080, 32'h0, 1, 32'h300, 1'b1, 32'h1084, "alias");
    probe(32'h1080, 1'b0, 32'h0, "alias_invalidated");

    // Bubble in Execute: no mispredict, no training
    drive_e(1'b0, 1, 0, 0, 1, 32'h10, 32'h50, 0, 32'h0);
    expect_out(K_MISP, 0, "bubble_misp");
    expect_out(K_REDIR, 32'h50, "bubble_redir");
    next_cycle();
    probe(32'h10, 1'b0, 32'h0, "bubble_no_train");

    // Reset during a pending write discards it and clears the table
    PCF = 32'h40;
    drive_e(1'b1, 1, 0, 0, 1, 32'hC0, 32'h60, 0, 32'h0);
    reset = 1'b1;
    #1;
    check_now(K_PTF, 0, "midreset_now_ptf");
    check_now(K_PTG, 0, "midreset_now_ptg");
    expect_out(K_PTF, 0, "midreset_ptf");
    expect_out(K_PTG, 0, "midreset_ptg");
    next_cycle();
    reset = 1'b0;
    probe(32'hC0, 1'b0, 32'h0, "midreset_discard");
    probe(32'h40, 1'b0, 32'h0, "midreset_cleared");
    expect_out(K_BCNT, 0, "midreset_bcnt");
    expect_out(K_MCNT, 0, "midreset_mcnt");
    next_cycle();

    // Ten branches, three mispredicts
    train(1, 0, 0, 1, 32'h40, 32'h20, 0, 32'h0, 1'b1, 32'h20, "s1");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s2");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s3");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s4");
    train(1, 0, 0, 0, 32'h40, 32'h20, 1, 32'h20, 1'b1, 32'h44, "s5");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s6");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s7");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s8");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h24, 1'b1, 32'h20, "s9");
    train(1, 0, 0, 1, 32'h40, 32'h20, 1, 32'h20, 1'b0, 32'h20, "s10");
    idle_e();
    expect_out(K_BCNT, STATS ? 32'd10 : 32'd0, "stats_branch");
    expect_out(K_MCNT, STATS ? 32'd3 : 32'd0, "stats_mispred");
    next_cycle();
    // Bubbles do not count
    next_cycle();
    expect_out(K_BCNT, STATS ? 32'd10 : 32'd0, "stats_branch_hold");
    expect_out(K_MCNT, STATS ? 32'd3 : 32'd0, "stats_mispred_hold");
    next_cycle();
    check_now(K_BCNT, STATS ? 32'd10 : 32'd0, "stats_branch_now");
    check_now(K_MCNT, STATS ? 32'd3 : 32'd0, "stats_mispred_now");

    @(negedge clk);
    #1;
    if (errors != 0)
        $display("FAIL summary: actual=%0d errors required=0", errors);
    else
        $display("PASS");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
